// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the handshaked data-memory controller:
//   - data-path width localparams
//   - access-size (memop) encodings
//   - controller FSM state encoding
//   - access_fault(): size/alignment legality of a request
// -----------------------------------------------------------------------------
package dm_pkg;

   localparam int DATA_W = 32;
   localparam int LANES  = DATA_W / 8;

   typedef enum logic [1:0] {
      MEMOP_W   = 2'b00,
      MEMOP_H   = 2'b01,
      MEMOP_B   = 2'b10,
      MEMOP_RSV = 2'b11
   } memop_e;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   // Reserved sizes and accesses not aligned to their own size are illegal.
   function automatic logic access_fault(memop_e op, logic [1:0] lane);
      case (op)
         MEMOP_W: return lane != 2'b00;
         MEMOP_H: return lane[0];
         MEMOP_B: return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/dm_align.sv
// -----------------------------------------------------------------------------
// dm_align
// Combinational lane steering between the CPU view (right-aligned data) and
// the little-endian 32-bit RAM word.
// Ports:
//   memop      in  access size (MEMOP_W/H/B/RSV)
//   ext        in  1 = sign-extend sub-word loads, 0 = zero-extend
//   lane       in  byte address bits [1:0]
//   wdata      in  right-aligned store data
//   rword      in  RAM word at the addressed location
//   wmask      out per-byte write enable
//   wdata_lane out store data replicated onto the selected lanes
//   rdata_ext  out selected lanes, right-aligned and extended
// -----------------------------------------------------------------------------
module dm_align
   import dm_pkg::*;
(
   input  logic [1:0]        memop,
   input  logic              ext,
   input  logic [1:0]        lane,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rword,
   output logic [LANES-1:0]  wmask,
   output logic [DATA_W-1:0] wdata_lane,
   output logic [DATA_W-1:0] rdata_ext
);

   logic [DATA_W-1:0] rshift;

   // Bring the addressed byte/half down to bit 0.
   assign rshift = rword >> {lane, 3'b000};

   always_comb begin
      // NOTE: every output is defaulted before the case so no path infers a latch.
      wmask      = '0;
      wdata_lane = wdata;
      rdata_ext  = rword;
      case (memop_e'(memop))
         MEMOP_W: wmask = 4'b1111;
         MEMOP_H: begin
            wmask      = lane[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {2{wdata[15:0]}};
            rdata_ext  = {{16{ext & rshift[15]}}, rshift[15:0]};
         end
         MEMOP_B: begin
            wmask      = 4'b0001 << lane;
            wdata_lane = {4{wdata[7:0]}};
            rdata_ext  = {{24{ext & rshift[7]}}, rshift[7:0]};
         end
         default: wmask = '0;
      endcase
   end

endmodule

// File: rtl/dm_ctrl.sv
// -----------------------------------------------------------------------------
// dm_ctrl
// Handshaked data-memory controller with configurable wait states,
// byte/half/word access, load extension and fault reporting.
// Ports:
//   clk        in  clock, rising edge
//   rst        in  synchronous reset, active-high
//   req_valid  in  request present
//   req_ready  out controller idle and able to accept
//   req_we     in  1 = store, 0 = load
//   req_addr   in  byte address
//   req_wdata  in  right-aligned store data
//   req_memop  in  00 word, 01 half, 10 byte, 11 reserved
//   req_ext    in  load extension, 1 = sign
//   resp_valid out one-cycle response pulse
//   resp_rdata out extended load data (0 for stores and faults), held
//   resp_err   out access faulted, held, qualified by resp_valid
// -----------------------------------------------------------------------------
module dm_ctrl
   import dm_pkg::*;
#(
   parameter int ADDR_WIDTH  = 9,
   parameter int DEPTH_WORDS = 128,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [1:0]            req_memop,
   input  logic                  req_ext,
   output logic                  resp_valid,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  resp_err
);

   localparam int                  IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(DEPTH_WORDS * 4);
   localparam logic [3:0]          LAST_WAIT  = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   state_e                state;
   logic [3:0]            wait_cnt;
   logic                  lat_we;
   logic                  lat_ext;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [DATA_W-1:0]     lat_wdata;
   logic [1:0]            lat_memop;

   logic                  in_idle;
   logic                  cur_we;
   logic                  cur_ext;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [DATA_W-1:0]     cur_wdata;
   logic [1:0]            cur_memop;
   logic                  fault;
   logic                  accept;
   logic                  wait_done;
   logic                  enter_resp;
   logic                  do_write;
   logic [IDX_W-1:0]      word_idx;
   logic [DATA_W-1:0]     rword;
   logic [LANES-1:0]      wmask;
   logic [DATA_W-1:0]     wdata_lane;
   logic [DATA_W-1:0]     load_data;

   logic [DATA_W-1:0]     mem [DEPTH_WORDS];

   assign in_idle   = (state == IDLE);
   assign req_ready = in_idle && !rst;

   // With zero wait states the access happens on the accept edge itself, so
   // the request being serviced comes straight from the ports while idle and
   // from the latched copy afterwards.
   assign cur_we    = in_idle ? req_we    : lat_we;
   assign cur_ext   = in_idle ? req_ext   : lat_ext;
   assign cur_addr  = in_idle ? req_addr  : lat_addr;
   assign cur_wdata = in_idle ? req_wdata : lat_wdata;
   assign cur_memop = in_idle ? req_memop : lat_memop;

   assign fault = access_fault(memop_e'(cur_memop), cur_addr[1:0])
                  || ({1'b0, cur_addr} >= ADDR_LIMIT);

   assign accept     = req_valid && req_ready;
   assign wait_done  = (state == WAIT) && (wait_cnt == LAST_WAIT);
   assign enter_resp = (accept && (fault || WAIT_CYCLES == 0)) || (!rst && wait_done);
   assign do_write   = enter_resp && !fault && cur_we;

   assign word_idx = cur_addr[2 +: IDX_W];
   assign rword    = mem[word_idx];

   dm_align u_align (
      .memop      (cur_memop),
      .ext        (cur_ext),
      .lane       (cur_addr[1:0]),
      .wdata      (cur_wdata),
      .rword      (rword),
      .wmask      (wmask),
      .wdata_lane (wdata_lane),
      .rdata_ext  (load_data)
   );

   // NOTE: the RAM array has no reset; enter_resp already excludes rst, so a
   // reset on the edge that would enter RESP suppresses the write.
   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int i = 0; i < LANES; i++) begin
            if (wmask[i]) mem[word_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
         end
      end
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         lat_we     <= 1'b0;
         lat_ext    <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_memop  <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_we    <= req_we;
                  lat_ext   <= req_ext;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  lat_memop <= req_memop;
                  wait_cnt  <= '0;
                  state     <= (fault || WAIT_CYCLES == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (wait_done) state <= RESP;
               else           wait_cnt <= wait_cnt + 4'd1;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
         if (enter_resp) begin
            resp_valid <= 1'b1;
            resp_err   <= fault;
            resp_rdata <= (fault || cur_we) ? '0 : load_data;
         end
      end
   end

endmodule
